// File: rtl/mem_pkg.sv
// Shared types for the core<->memory request link: request/response payload,
// opcode encoding and the default sizing of the memory responder.
package mem_pkg;

  localparam int DEF_NUM_CORES = 4;
  localparam int DEF_MEM_DEPTH = 1024;
  localparam int CORE_ID_W     = 2;
  localparam int ADDR_W        = 32;
  localparam int DATA_W        = 32;

  typedef enum logic {
    MEM_READ  = 1'b0,
    MEM_WRITE = 1'b1
  } opcode_e;

  typedef struct packed {
    logic                 vld;
    opcode_e              opcode;
    logic [CORE_ID_W-1:0] core_id;
    logic [6:0]           access_id;
    logic [ADDR_W-1:0]    addr;
    logic [DATA_W-1:0]    data;
  } request_t;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_req_fifo.sv
// Per-core synchronous request FIFO. The caller guarantees push only when
// there is room (or a pop happens the same cycle) and pop only when non-empty.
module mem_req_fifo
  import mem_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push_i,
  input  request_t data_i,
  input  logic     pop_i,
  output request_t data_o,
  output logic     full_o,
  output logic     empty_o
);

  localparam int PW = $clog2(FIFO_DEPTH);

  request_t       store_q [FIFO_DEPTH];
  logic [PW:0]    wr_ptr_q;
  logic [PW:0]    rd_ptr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) store_q[wr_ptr_q[PW-1:0]] <= data_i;
  end

  // Extra pointer bit separates the full and empty cases when indices match.
  assign data_o  = store_q[rd_ptr_q[PW-1:0]];
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

endmodule

// File: rtl/mem_responder.sv
// Memory-side endpoint: per-core request FIFOs, round-robin issue into an on-chip
// word array, fixed-latency response pipe. Define MEM_RSP_WRITE_ACK_EN to acknowledge writes.
module mem_responder
  import mem_pkg::*;
#(
  parameter int NUM_CORES    = DEF_NUM_CORES,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  request_t             core_req [NUM_CORES],
  output request_t             core_rsp [NUM_CORES],
  output logic [NUM_CORES-1:0] fifo_overflow,
  output logic                 init_done
);

  localparam int AW = $clog2(MEM_DEPTH);
  localparam int CW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  state_e               state_q;
  logic [AW-1:0]        init_addr_q;
  logic                 init_done_q;
  logic [CW-1:0]        rr_q;
  logic [NUM_CORES-1:0] ovf_q;
  logic [READ_LATENCY:0] vld_q;
  request_t             pay_q [READ_LATENCY+1];
  logic [CW-1:0]        src_q [READ_LATENCY+1];

  logic [NUM_CORES-1:0] req_vld, push, pop, full, empty, drop;
  request_t             head [NUM_CORES];
  logic [CW-1:0]        grant;
  logic                 grant_vld;
  request_t             iss;
  logic [AW-1:0]        iss_idx;
  logic                 rsp_en;
  request_t             rsp_pay;

  logic [DATA_W-1:0]    mem_q [MEM_DEPTH];
  logic                 mem_we;
  logic [AW-1:0]        mem_waddr;
  logic [DATA_W-1:0]    mem_wdata;

  function automatic logic [CW-1:0] next_idx(input logic [CW-1:0] i);
    return (int'(i) == NUM_CORES - 1) ? '0 : i + 1'b1;
  endfunction

  function automatic logic [CW-1:0] rot(input logic [CW-1:0] base, input int k);
    int s;
    s = (int'(base) + k) % NUM_CORES;
    return CW'(s);
  endfunction

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_fifo
    assign req_vld[c] = core_req[c].vld;
    // A push into a full FIFO is still taken when the head leaves that same cycle.
    assign push[c]    = req_vld[c] && (!full[c] || pop[c]);
    assign drop[c]    = req_vld[c] && full[c] && !pop[c];

    mem_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push[c]),
      .data_i  (core_req[c]),
      .pop_i   (pop[c]),
      .data_o  (head[c]),
      .full_o  (full[c]),
      .empty_o (empty[c])
    );

    assign core_rsp[c] = (vld_q[READ_LATENCY] && (src_q[READ_LATENCY] == CW'(c)))
                         ? pay_q[READ_LATENCY] : '0;
  end

  always_comb begin
    grant     = rr_q;
    grant_vld = 1'b0;
    pop       = '0;
    if (state_q == ST_RUN) begin
      for (int k = NUM_CORES - 1; k >= 0; k--) begin
        if (!empty[rot(rr_q, k)]) begin
          grant     = rot(rr_q, k);
          grant_vld = 1'b1;
        end
      end
    end
    if (grant_vld) pop[grant] = 1'b1;
  end

  assign iss     = head[grant];
  assign iss_idx = iss.addr[AW-1:0];

`ifdef MEM_RSP_WRITE_ACK_EN
  assign rsp_en = grant_vld;
`else
  assign rsp_en = grant_vld && (iss.opcode == MEM_READ);
`endif

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = iss_idx;
    mem_wdata = iss.data;
    if (state_q == ST_INIT) begin
      mem_we    = 1'b1;
      mem_waddr = init_addr_q;
      mem_wdata = '0;
    end else if (grant_vld && (iss.opcode == MEM_WRITE)) begin
      mem_we    = 1'b1;
    end
  end

  always_comb begin
    rsp_pay      = iss;
    rsp_pay.data = (iss.opcode == MEM_WRITE) ? '0 : mem_q[iss_idx];
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      init_addr_q <= '0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == AW'(MEM_DEPTH - 1)) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN:  state_q <= ST_RUN;
        default: state_q <= ST_INIT;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q  <= '0;
      ovf_q <= '0;
      vld_q <= '0;
    end else begin
      if (grant_vld) rr_q <= next_idx(grant);
      ovf_q <= ovf_q | drop;
      vld_q <= {vld_q[READ_LATENCY-1:0], rsp_en};
    end
  end

  // Response payload stage 0 is loaded at issue; stage READ_LATENCY drives the ports.
  always_ff @(posedge clk) begin
    pay_q[0] <= rsp_pay;
    src_q[0] <= grant;
    for (int s = 1; s <= READ_LATENCY; s++) begin
      pay_q[s] <= pay_q[s-1];
      src_q[s] <= src_q[s-1];
    end
  end

  assign fifo_overflow = ovf_q;
  assign init_done     = init_done_q;

endmodule
